// File: rtl/param_menu_select.sv
// -----------------------------------------------------------------------------
// param_menu_select
//
// Front-panel menu controller. A single debounced select key cycles a one-hot
// selection through NUM_PARAMS parameter cells (none -> 0 -> 1 -> ... -> none).
// Holding the key for LONG_PRESS_MS asks the selected cell to restore its
// default value, and does not move the selection. The block also provides a
// 1 ms square wave that the parameter cells use as their own time base.
//
// Optional feature: define PARAM_MENU_TIMEOUT_EN to deselect automatically
// after TIMEOUT_MS of inactivity while a cell is selected.
//
// Ports
//   clk          in   system clock, all logic on its rising edge
//   resetn       in   asynchronous active-low reset
//   akey_sel     in   raw select key, 1 = released, asynchronous to clk
//   key_activity in   one-cycle pulse per up/down key event from the cells
//   clk_ms       out  1 ms period square wave
//   selected     out  one-hot cell select, all-zero = none
//   restore      out  one-cycle restore-default pulse
//   sel_index    out  current index, NUM_PARAMS = none
// -----------------------------------------------------------------------------
module param_menu_select #(
  parameter int CLK_FREQ      = 50_000000,
  parameter int NUM_PARAMS    = 4,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 1000,
  parameter int TIMEOUT_MS    = 10000
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  akey_sel,
  input  logic                                  key_activity,
  output logic                                  clk_ms,
  output logic [NUM_PARAMS-1:0]                 selected,
  output logic                                  restore,
  output logic [$clog2(NUM_PARAMS+1)-1:0]       sel_index
);

  localparam int HALF   = CLK_FREQ / 2000;
  localparam int DIV_W  = $clog2(HALF + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_MS + 1);
  localparam int IDX_W  = $clog2(NUM_PARAMS + 1);

  localparam logic [IDX_W-1:0] NONE = IDX_W'(NUM_PARAMS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PARAMS - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_t;

  // ---------------------------------------------------------------------------
  // Millisecond divider
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;
  logic             ms_tick;

  assign div_wrap = (div_cnt == DIV_W'(HALF - 1));
  // The tick marks the cycle in which clk_ms is about to rise.
  assign ms_tick  = div_wrap & ~clk_ms;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
      clk_ms  <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      clk_ms  <= ~clk_ms;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Key synchroniser (idle level is released = 1)
  // ---------------------------------------------------------------------------
  logic key_meta;
  logic key_sync;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= akey_sel;
      key_sync <= key_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Key FSM
  // ---------------------------------------------------------------------------
  key_state_t        state;
  key_state_t        state_next;
  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              long_flag;
  logic              deb_last;
  logic              hold_sat;
  logic              deb_clr, deb_inc;
  logic              hold_clr, hold_inc;
  logic              long_clr, long_set;
  logic              restore_fire;
  logic              advance;

  assign deb_last = (deb_cnt == DEB_W'(DEBOUNCE_MS - 1));
  assign hold_sat = (hold_cnt == HOLD_W'(LONG_PRESS_MS));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= RELEASED;
    else         state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    deb_clr      = 1'b0;
    deb_inc      = 1'b0;
    hold_clr     = 1'b0;
    hold_inc     = 1'b0;
    long_clr     = 1'b0;
    long_set     = 1'b0;
    restore_fire = 1'b0;
    advance      = 1'b0;
    unique case (state)
      RELEASED: begin
        if (!key_sync) begin
          state_next = PRESS_WAIT;
          deb_clr    = 1'b1;
        end
      end
      PRESS_WAIT: begin
        if (key_sync) begin
          state_next = RELEASED;
        end else if (ms_tick) begin
          if (deb_last) begin
            state_next = PRESSED;
            hold_clr   = 1'b1;
            long_clr   = 1'b1;
          end else begin
            deb_inc = 1'b1;
          end
        end
      end
      PRESSED: begin
        if (key_sync) begin
          state_next = RELEASE_WAIT;
          deb_clr    = 1'b1;
        end else if (ms_tick && !hold_sat) begin
          hold_inc = 1'b1;
          // The hold counter saturates at the threshold, so this fires once.
          if (hold_cnt == HOLD_W'(LONG_PRESS_MS - 1)) begin
            long_set     = 1'b1;
            restore_fire = (sel_index != NONE);
          end
        end
      end
      RELEASE_WAIT: begin
        if (!key_sync) begin
          state_next = PRESSED;
        end else if (ms_tick) begin
          if (deb_last) begin
            state_next = RELEASED;
            advance    = ~long_flag;
          end else begin
            deb_inc = 1'b1;
          end
        end
      end
      default: state_next = RELEASED;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      long_flag <= 1'b0;
      restore   <= 1'b0;
    end else begin
      if (deb_clr)      deb_cnt <= '0;
      else if (deb_inc) deb_cnt <= deb_cnt + 1'b1;

      if (hold_clr)      hold_cnt <= '0;
      else if (hold_inc) hold_cnt <= hold_cnt + 1'b1;

      if (long_clr)      long_flag <= 1'b0;
      else if (long_set) long_flag <= 1'b1;

      restore <= restore_fire;
    end
  end

  // ---------------------------------------------------------------------------
  // Selection
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]      sel_next;
  logic [NUM_PARAMS-1:0] sel_onehot;
  logic                  idle_hit;

`ifdef PARAM_MENU_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_MS + 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_clr;

  assign idle_clr = key_activity | (state_next != state) | (sel_index == NONE);
  // Any FSM transition clears the counter, so an advance always beats a timeout.
  assign idle_hit = ms_tick & ~idle_clr & (idle_cnt == IDLE_W'(TIMEOUT_MS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                   idle_cnt <= '0;
    else if (idle_clr || idle_hit) idle_cnt <= '0;
    else if (ms_tick)              idle_cnt <= idle_cnt + 1'b1;
  end
`else
  logic unused_cfg;

  assign idle_hit   = 1'b0;
  assign unused_cfg = key_activity ^ (TIMEOUT_MS == 0);
`endif

  always_comb begin
    sel_next = sel_index;
    if (advance) begin
      if (sel_index == NONE)      sel_next = '0;
      else if (sel_index == LAST) sel_next = NONE;
      else                        sel_next = sel_index + 1'b1;
    end else if (idle_hit) begin
      sel_next = NONE;
    end

    sel_onehot = '0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      sel_onehot[i] = (sel_next == IDX_W'(i));
    end
  end

  // Decoding from sel_next keeps selected and sel_index in lock-step.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_index <= NONE;
      selected  <= '0;
    end else begin
      sel_index <= sel_next;
      selected  <= sel_onehot;
    end
  end

endmodule

// File: tb/tb_param_menu_select.sv
// -----------------------------------------------------------------------------
// tb_param_menu_select
//
// Directed bench for param_menu_select with CLK_FREQ=10000 (10 clocks per ms),
// NUM_PARAMS=3, DEBOUNCE_MS=2, LONG_PRESS_MS=10, TIMEOUT_MS=20. Expected values
// follow the PARAM_MENU_TIMEOUT_EN macro when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_param_menu_select;

  localparam int CYC_PER_MS = 10;

  logic       clk;
  logic       resetn;
  logic       akey_sel;
  logic       key_activity;
  logic       clk_ms;
  logic [2:0] selected;
  logic       restore;
  logic [1:0] sel_index;

  int total;
  int passed;
  int restore_count;
  int restore_run;
  int restore_max_run;

  param_menu_select #(
    .CLK_FREQ     (10000),
    .NUM_PARAMS   (3),
    .DEBOUNCE_MS  (2),
    .LONG_PRESS_MS(10),
    .TIMEOUT_MS   (20)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .akey_sel    (akey_sel),
    .key_activity(key_activity),
    .clk_ms      (clk_ms),
    .selected    (selected),
    .restore     (restore),
    .sel_index   (sel_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Restore pulse monitor: number of pulses and the longest run of high cycles.
  always @(negedge clk) begin
    if (restore) begin
      restore_count <= restore_count + 1;
      restore_run   <= restore_run + 1;
      if (restore_run + 1 > restore_max_run) restore_max_run <= restore_run + 1;
    end else begin
      restore_run <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the key low for the given number of ms, release, and allow the
  // release debounce (2 ms plus synchroniser) to complete.
  task automatic press(input int ms);
    akey_sel = 1'b0;
    wait_cycles(ms * CYC_PER_MS);
    akey_sel = 1'b1;
    wait_cycles(40);
  endtask

  // Cycles until clk_ms next changes, bounded; 99 means it never changed.
  task automatic cycles_to_toggle(output int n);
    logic prev;
    prev = clk_ms;
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (clk_ms !== prev) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    total           = 0;
    passed          = 0;
    restore_count   = 0;
    restore_run     = 0;
    restore_max_run = 0;
    resetn          = 1'b0;
    akey_sel        = 1'b1;
    key_activity    = 1'b0;

    // Reset state
    wait_cycles(4);
    check("reset clk_ms",    32'(clk_ms),    32'd0);
    check("reset selected",  32'(selected),  32'b000);
    check("reset sel_index", 32'(sel_index), 32'd3);
    check("reset restore",   32'(restore),   32'd0);

    // Divider: first rise 5 cycles after release, then toggles every 5
    resetn = 1'b1;
    cycles_to_toggle(n);
    check("clk_ms first rise", 32'(n), 32'd5);
    check("clk_ms high level", 32'(clk_ms), 32'd1);
    cycles_to_toggle(n);
    check("clk_ms high half", 32'(n), 32'd5);
    cycles_to_toggle(n);
    check("clk_ms low half", 32'(n), 32'd5);

    // Four clean short presses walk the selection and wrap to none
    press(4);
    check("press1 selected",  32'(selected),  32'b001);
    check("press1 sel_index", 32'(sel_index), 32'd0);
    press(4);
    check("press2 selected",  32'(selected),  32'b010);
    check("press2 sel_index", 32'(sel_index), 32'd1);
    press(4);
    check("press3 selected",  32'(selected),  32'b100);
    check("press3 sel_index", 32'(sel_index), 32'd2);
    press(4);
    check("press4 selected",  32'(selected),  32'b000);
    check("press4 sel_index", 32'(sel_index), 32'd3);
    check("short presses no restore", 32'(restore_count), 32'd0);

    // Glitches: one clock low, then 1 ms low
    akey_sel = 1'b0;
    wait_cycles(1);
    akey_sel = 1'b1;
    wait_cycles(30);
    check("glitch 1cyc selected", 32'(selected), 32'b000);
    akey_sel = 1'b0;
    wait_cycles(CYC_PER_MS);
    akey_sel = 1'b1;
    wait_cycles(40);
    check("glitch 1ms selected",  32'(selected),  32'b000);
    check("glitch 1ms sel_index", 32'(sel_index), 32'd3);

    // Long press with index 1 selected: one restore, no advance
    press(4);
    press(4);
    check("pre-long selected", 32'(selected), 32'b010);
    press(15);
    check("long restore count",   32'(restore_count),   32'd1);
    check("long restore width",   32'(restore_max_run), 32'd1);
    check("long selected kept",   32'(selected),        32'b010);
    check("long sel_index kept",  32'(sel_index),       32'd1);

    // Long press with nothing selected: no restore, no advance
    press(4);
    press(4);
    check("pre-none-long selected", 32'(selected), 32'b000);
    press(15);
    check("none long restore count", 32'(restore_count), 32'd1);
    check("none long selected",      32'(selected),      32'b000);

    // Inactivity: select 0, activity at ~10 ms, then idle
    press(4);
    check("timeout sel start", 32'(selected), 32'b001);
    wait_cycles(80);
    key_activity = 1'b1;
    wait_cycles(1);
    key_activity = 1'b0;
    wait_cycles(150);
    check("activity holds selection", 32'(selected), 32'b001);
    wait_cycles(100);
`ifdef PARAM_MENU_TIMEOUT_EN
    check("idle selected",  32'(selected),  32'b000);
    check("idle sel_index", 32'(sel_index), 32'd3);
`else
    check("idle selected",  32'(selected),  32'b001);
    check("idle sel_index", 32'(sel_index), 32'd0);
`endif

    // Reset mid-press aborts; a key still held must debounce again
    akey_sel = 1'b0;
    wait_cycles(60);
    resetn = 1'b0;
    wait_cycles(3);
    check("midpress reset selected",  32'(selected),  32'b000);
    check("midpress reset sel_index", 32'(sel_index), 32'd3);
    check("midpress reset restore",   32'(restore),   32'd0);
    resetn = 1'b1;
    wait_cycles(5 * CYC_PER_MS);
    akey_sel = 1'b1;
    wait_cycles(40);
    check("post-reset press selected", 32'(selected),      32'b001);
    check("post-reset restore count",  32'(restore_count), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/param_menu_select.md
PARAM_MENU_SELECT -- requirements
Module: param_menu_select

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000000, system clock frequency in Hz.
REQ-002 SHALL have parameter NUM_PARAMS, default 4, number of parameter cells served; range 1..15.
REQ-003 SHALL have parameter DEBOUNCE_MS, default 20, select-key stable time in ms.
REQ-004 SHALL have parameter LONG_PRESS_MS, default 1000, hold time that triggers restore.
REQ-005 SHALL have parameter TIMEOUT_MS, default 10000, inactivity time before auto-deselect.
REQ-006 SHALL have port clk  input  1  system clock; the only clock; all logic on its rising edge.
REQ-007 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port akey_sel  input  1  raw select key; 1 = released, asynchronous to clk.
REQ-009 SHALL have port key_activity  input  1  one-cycle pulse per up/down key event from downstream cells.
REQ-010 SHALL have port clk_ms  output  1  1 ms period square wave, fed to param cells.
REQ-011 SHALL have port selected  output  NUM_PARAMS  one-hot cell select; all-zero = none.
REQ-012 SHALL have port restore  output  1  one-cycle restore-default pulse.
REQ-013 SHALL have port sel_index  output  $clog2(NUM_PARAMS+1)  current index; NUM_PARAMS = none.

Function
REQ-014 SHALL toggle clk_ms every CLK_FREQ/2000 clk cycles via a divider counter that wraps to 0; an internal one-cycle ms_tick SHALL fire on each 0->1 transition of clk_ms.
REQ-015 SHALL synchronise akey_sel through two flops (reset value 1) before any use.
REQ-016 SHALL run key FSM RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT; RELEASED->PRESS_WAIT on sync key 0.
REQ-017 In PRESS_WAIT: key 1 -> RELEASED (glitch, no action); DEBOUNCE_MS ms_ticks with key 0 -> PRESSED, hold counter cleared, long flag cleared.
REQ-018 In PRESSED: hold counter increments per ms_tick, saturating; key 1 -> RELEASE_WAIT with debounce counter cleared.
REQ-019 When hold counter reaches LONG_PRESS_MS, restore SHALL pulse exactly one cycle only if sel_index != NUM_PARAMS, and long flag SHALL set; no further restore until next press.
REQ-020 In RELEASE_WAIT: key 0 -> PRESSED with hold counter preserved; DEBOUNCE_MS ticks with key 1 -> RELEASED.
REQ-021 On RELEASE_WAIT->RELEASED with long flag clear, selection SHALL advance: none->0, i->i+1, NUM_PARAMS-1->none (wrap).
REQ-022 selected SHALL be the registered one-hot decode of sel_index, updated in the same cycle as sel_index.
REQ-023 A long press SHALL never advance the selection.

Reset
REQ-024 While resetn=0: clk_ms=0, divider=0, selected=0, sel_index=NUM_PARAMS, restore=0, FSM=RELEASED, all counters and flags 0.
REQ-025 Reset asserted mid-press SHALL abort without restore or advance; after release, a key still held SHALL require full debounce again.

Configuration
REQ-026 With macro PARAM_MENU_TIMEOUT_EN defined, an idle counter SHALL count ms_ticks while a cell is selected, clear on key_activity, any FSM transition, or none-state, and force sel_index=none on reaching TIMEOUT_MS; an advance in the same cycle SHALL win.
REQ-027 Without PARAM_MENU_TIMEOUT_EN, no idle counter SHALL exist and selection persists indefinitely; key_activity is ignored.

Verification (CLK_FREQ=10000, NUM_PARAMS=3, DEBOUNCE_MS=2, LONG_PRESS_MS=10, TIMEOUT_MS=20)
REQ-028 Reset release -> clk_ms toggles every 5 cycles (period 10); selected=000, sel_index=3, restore=0.
REQ-029 Four clean short presses (4 ms low) -> selected 001, 010, 100, 000 after each release debounce; restore never pulses.
REQ-030 1-cycle and 1 ms glitches low on akey_sel -> no state change, selected unchanged.
REQ-031 Select index 1, hold key 15 ms -> single restore pulse at 10 ms hold, selected stays 010 after release.
REQ-032 Hold 15 ms with none selected -> no restore, selection stays 000.
REQ-033 With PARAM_MENU_TIMEOUT_EN: select index 0, key_activity at 10 ms, then idle 20 ms -> selected 000; without macro -> stays 001.
